// File: rtl/centroid_calc_pkg.sv
// rtl/centroid_calc_pkg.sv - shared widths and FSM encoding for the centroid extractor
// Contents: coordinate widths, accumulator widths, divider iteration width,
//           centroid FSM state encoding.
package centroid_calc_pkg;

    localparam int X_W    = 11;   // hcount / centroid column width
    localparam int Y_W    = 10;   // vcount / centroid line width
    localparam int SUM_W  = 32;   // coordinate sum accumulators
    localparam int CNT_W  = 20;   // hit counter
    localparam int ITER_W = 5;    // 32 divider iterations

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } state_t;

endpackage

// File: rtl/centroid_calc_seq_divider.sv
// rtl/centroid_calc_seq_divider.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : load operands and begin; restarts any division in flight
//   dividend    : numerator, captured on start
//   divisor     : denominator, captured on start (must be non-zero)
//   quotient    : result, final 32 cycles after start
//   busy        : high while iterations remain
module seq_divider
    import centroid_calc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             busy
);

    logic [SUM_W-1:0]  rem;
    logic [SUM_W-1:0]  quo;
    logic [SUM_W-1:0]  dvs;
    logic [ITER_W-1:0] iter;
    logic [SUM_W:0]    shifted;
    logic [SUM_W:0]    diff;

    // Dividend bits shift out of the top of quo into rem while quotient
    // bits shift in at the bottom, so quo ends up holding the quotient.
    always_comb begin
        shifted = {rem, quo[SUM_W-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
            iter <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
            iter <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (!diff[SUM_W]) begin
                rem <= diff[SUM_W-1:0];
                quo <= {quo[SUM_W-2:0], 1'b1};
            end else begin
                rem <= shifted[SUM_W-1:0];
                quo <= {quo[SUM_W-2:0], 1'b0};
            end
            iter <= iter + 5'd1;
            if (iter == 5'd31) begin
                busy <= 1'b0;
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/centroid_calc.sv
// rtl/centroid_calc.sv - per-frame centroid of threshold hits with registered (x, y) result
// Ports:
//   clk, reset       : pixel clock, synchronous active-high reset
//   hcount, vcount   : current pixel position
//   hit              : current pixel passed the colour threshold
//   new_frame        : one-cycle frame boundary pulse
//   x, y             : registered centroid of the last resolved valid frame
//   valid            : x/y come from a frame with at least MIN_COUNT hits
//   done             : one-cycle pulse when a frame result is resolved
module centroid_calc
    import centroid_calc_pkg::*;
#(
    parameter int H_ACTIVE  = 1024,
    parameter int V_ACTIVE  = 768,
    parameter int MIN_COUNT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] hcount,
    input  logic [Y_W-1:0] vcount,
    input  logic           hit,
    input  logic           new_frame,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           valid,
    output logic           done
);

    localparam logic [X_W:0]     H_LIM   = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W:0]     V_LIM   = (Y_W + 1)'(V_ACTIVE);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

    logic [SUM_W-1:0]  sum_x;
    logic [SUM_W-1:0]  sum_y;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  snap_count;
    logic              frame_pend;
    logic              frame_ok;
    logic              in_area;
    state_t            state;
    logic [ITER_W-1:0] iter;
    logic [SUM_W-1:0]  quot_x;
    logic [SUM_W-1:0]  quot_y;
    logic              busy_x;
    logic              busy_y;
    logic              unused_bits;

    assign in_area = hit && ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);

    // Accumulators: a hit coinciding with new_frame starts the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (new_frame) begin
            sum_x <= in_area ? SUM_W'(hcount) : '0;
            sum_y <= in_area ? SUM_W'(vcount) : '0;
            count <= in_area ? CNT_W'(1) : '0;
        end else if (in_area) begin
            sum_x <= sum_x + SUM_W'(hcount);
            sum_y <= sum_y + SUM_W'(vcount);
            count <= count + CNT_W'(1);
        end
    end

    // Dividers capture the sums directly at the frame boundary; the FSM
    // decides one cycle later from the registered count snapshot, which
    // is what places FINISH 33 edges after new_frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_count <= '0;
            frame_pend <= 1'b0;
        end else begin
            frame_pend <= new_frame;
            if (new_frame) begin
                snap_count <= count;
            end
        end
    end

    seq_divider u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (new_frame),
        .dividend (sum_x),
        .divisor  (SUM_W'(count)),
        .quotient (quot_x),
        .busy     (busy_x)
    );

    seq_divider u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (new_frame),
        .dividend (sum_y),
        .divisor  (SUM_W'(count)),
        .quotient (quot_y),
        .busy     (busy_y)
    );

    // Quotients are bounded by the active area, so their high bits are zero.
    assign unused_bits = ^{quot_x[SUM_W-1:X_W], quot_y[SUM_W-1:Y_W], busy_x, busy_y};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            iter     <= '0;
            frame_ok <= 1'b0;
            x        <= '0;
            y        <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (new_frame) begin
                // Abandon any frame in flight; the pending snapshot is
                // evaluated from IDLE on the next cycle.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_pend) begin
                            if (snap_count < MIN_CNT) begin
                                frame_ok <= 1'b0;
                                state    <= FINISH;
                            end else begin
                                frame_ok <= 1'b1;
                                iter     <= '0;
                                state    <= DIVIDE;
                            end
                        end
                    end
                    DIVIDE: begin
                        if (iter == 5'd31) begin
                            state <= FINISH;
                        end else begin
                            iter <= iter + 5'd1;
                        end
                    end
                    FINISH: begin
                        if (frame_ok) begin
                            x     <= quot_x[X_W-1:0];
                            y     <= quot_y[Y_W-1:0];
                            valid <= 1'b1;
                        end else begin
                            valid <= 1'b0;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_centroid_calc.sv
// tb/tb_centroid_calc.sv - scoreboard bench for centroid_calc
module tb_centroid_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hit;
    logic        new_frame;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        done;

    typedef struct {
        logic [10:0] ex;
        logic [9:0]  ey;
        logic        ev;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    longint msx;
    longint msy;
    int     mcnt;
    logic [10:0] px;
    logic [9:0]  py;

    centroid_calc dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .hit       (hit),
        .new_frame (new_frame),
        .x         (x),
        .y         (y),
        .valid     (valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic hv);
        hcount = 11'(h);
        vcount = 10'(v);
        hit    = hv;
        if (hv && h < 1024 && v < 768) begin
            msx += h;
            msy += v;
            mcnt++;
        end
        tick();
        hit = 1'b0;
    endtask

    // Frame boundary; the optional pixel on the same cycle opens the next frame.
    task automatic pulse(input int h, input int v, input logic hv, input logic push);
        exp_t e;
        if (mcnt < 16) begin
            e.ex = px; e.ey = py; e.ev = 1'b0; e.lat = 2;
        end else begin
            e.ex = 11'(msx / mcnt); e.ey = 10'(msy / mcnt); e.ev = 1'b1; e.lat = 34;
        end
        if (push) begin
            sb.push_back(e);
            px = e.ex;
            py = e.ey;
        end
        msx = 0; msy = 0; mcnt = 0;
        hcount = 11'(h);
        vcount = 10'(v);
        hit    = hv;
        if (hv && h < 1024 && v < 768) begin
            msx = h; msy = v; mcnt = 1;
        end
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        hit = 1'b0;
    endtask

    task automatic wait_result(input string name);
        exp_t e;
        int   n = 0;
        logic got = 1'b0;
        e = sb.pop_front();
        while (n < 60 && !got) begin
            tick();
            n++;
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 60 cycles, required latency %0d", name, e.lat);
        end else begin
            if (n !== e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
            end
            checks++;
            if (x !== e.ex) begin
                errors++;
                $display("FAIL %s x: got %0d required %0d", name, x, e.ex);
            end
            checks++;
            if (y !== e.ey) begin
                errors++;
                $display("FAIL %s y: got %0d required %0d", name, y, e.ey);
            end
            checks++;
            if (valid !== e.ev) begin
                errors++;
                $display("FAIL %s valid: got %0b required %0b", name, valid, e.ev);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_width: got %0b required 0", name, done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hcount = '0; vcount = '0; hit = 1'b0; new_frame = 1'b0;
        msx = 0; msy = 0; mcnt = 0; px = '0; py = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({x, y, valid, done} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got x=%0d y=%0d valid=%0b done=%0b required all 0", x, y, valid, done);
        end
    endtask

    task automatic test_block();
        for (int v = 50; v <= 53; v++)
            for (int h = 100; h <= 103; h++)
                pix(h, v, 1'b1);
        pulse(0, 0, 1'b0, 1'b1);
        wait_result("block");
        checks++;
        if (x !== 11'd101 || y !== 10'd51) begin
            errors++;
            $display("FAIL block_const: got (%0d,%0d) required (101,51)", x, y);
        end
    endtask

    task automatic test_skip();
        for (int i = 0; i < 15; i++) pix(10 + i, 10, 1'b1);
        // hit on the boundary cycle belongs to the following frame
        pulse(200, 300, 1'b1, 1'b1);
        wait_result("skip");
    endtask

    task automatic test_out_of_area();
        for (int i = 0; i < 15; i++) begin
            pix(200, 300, 1'b1);
            case (i % 5)
                0: pix(1024, 60, 1'b1);
                1: pix(2047, 60, 1'b1);
                2: pix(300, 768, 1'b1);
                3: pix(300, 1023, 1'b1);
                default: pix(1500, 900, 1'b1);
            endcase
        end
        pulse(0, 0, 1'b0, 1'b1);
        wait_result("out_of_area");
        checks++;
        if (x !== 11'd200 || y !== 10'd300) begin
            errors++;
            $display("FAIL out_of_area_const: got (%0d,%0d) required (200,300)", x, y);
        end
    endtask

    task automatic test_large_sums();
        for (int i = 0; i < 30000; i++) begin
            if (i % 2 == 0) pix(1023, 767, 1'b1);
            else            pix(0, 0, 1'b1);
        end
        pulse(0, 0, 1'b0, 1'b1);
        wait_result("large_sums");
        checks++;
        if (x !== 11'd511 || y !== 10'd383) begin
            errors++;
            $display("FAIL large_sums_const: got (%0d,%0d) required (511,383)", x, y);
        end
    endtask

    task automatic test_abort();
        int d0;
        for (int i = 0; i < 16; i++) pix(40, 20, 1'b1);
        d0 = done_seen;
        pulse(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) pix(600, 400, 1'b1);
        pulse(0, 0, 1'b0, 1'b1);
        checks++;
        if (done_seen !== d0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses required 0", done_seen - d0);
        end
        wait_result("abort_second");
    endtask

    task automatic test_reset_mid();
        int d0;
        for (int i = 0; i < 16; i++) pix(700, 500, 1'b1);
        pulse(0, 0, 1'b0, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({x, y, valid, done} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got x=%0d y=%0d valid=%0b done=%0b required all 0", x, y, valid, done);
        end
        msx = 0; msy = 0; mcnt = 0; px = '0; py = '0;
        d0 = done_seen;
        repeat (40) tick();
        checks++;
        if (done_seen !== d0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got %0d done pulses required 0", done_seen - d0);
        end
        for (int v = 9; v <= 12; v++)
            for (int h = 5; h <= 8; h++)
                pix(h, v, 1'b1);
        pulse(0, 0, 1'b0, 1'b1);
        wait_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_block();
        test_skip();
        test_out_of_area();
        test_large_sums();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
